// File: rtl/cpu_defs_pkg.sv
// Shared widths, field positions, opcodes and buffer state encodings
// for the 16-bit CSC142 datapath.
package cpu_defs;

  localparam int DATA_WIDTH   = 16;
  localparam int OPCODE_WIDTH = 4;
  localparam int REG_WIDTH    = 4;
  localparam int IMM_WIDTH    = 4;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP      = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  function automatic logic [OPCODE_WIDTH-1:0] get_opcode(
    input logic [DATA_WIDTH-1:0] instr
  );
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready skid buffer with registered o_ready.
// Ports: i_valid/o_ready/i_data in, o_valid/i_ready/o_data out, i_flush, i_hold.
module skid_buffer2
  import cpu_defs::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_hold,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  buf_state_e   r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         r_ready;
  logic         w_push;
  logic         w_pop;

  assign o_valid = (r_state != ST_EMPTY);
  assign o_ready = r_ready;
  assign o_data  = r_head;
  assign w_push  = i_valid & r_ready;
  assign w_pop   = o_valid & i_ready;

  // r_ready tracks the next state: low when full or when i_hold
  // (halt) blocks further fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b1;
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_state <= ST_ONE;
            r_head  <= i_data;
          end
          r_ready <= ~i_hold;
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            r_state <= ST_TWO;
            r_skid  <= i_data;
            r_ready <= 1'b0;
          end else begin
            if (w_push) begin
              r_head <= i_data;
            end else if (w_pop) begin
              r_state <= ST_EMPTY;
            end
            r_ready <= ~i_hold;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_state <= ST_ONE;
            r_head  <= r_skid;
            r_ready <= ~i_hold;
          end else begin
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode register: buffers {pc, instr}, slices decode fields.
// Ports: in_* from fetch, out_* to decode, flush, halted status.
module if_id_stage
  import cpu_defs::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_instr,
  input  logic [DATA_WIDTH-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic [REG_WIDTH-1:0]    out_rd,
  output logic [REG_WIDTH-1:0]    out_rs,
  output logic [IMM_WIDTH-1:0]    out_imm,
  output logic [DATA_WIDTH-1:0]   out_pc,
  output logic                    halted
);

  logic                    r_halted;
  logic                    w_push;
  logic                    w_halt_acc;
  logic                    w_hold;
  logic [2*DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0]   w_instr;

  assign w_push     = in_valid & in_ready;
  assign w_halt_acc = w_push & (get_opcode(in_instr) == HALT_OPCODE);
  // Intake closes the cycle after a HALT is accepted.
  assign w_hold     = r_halted | w_halt_acc;

  skid_buffer2 #(
    .W(2*DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_hold  (w_hold),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  ({in_pc, in_instr}),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_halted <= 1'b0;
    end else if (w_halt_acc) begin
      r_halted <= 1'b1;
    end
  end

  assign w_instr    = w_head[DATA_WIDTH-1:0];
  assign out_pc     = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_opcode = w_instr[OP_MSB:OP_LSB];
  assign out_rd     = w_instr[RD_MSB:RD_LSB];
  assign out_rs     = w_instr[RS_MSB:RS_LSB];
  assign out_imm    = w_instr[IMM_MSB:IMM_LSB];
  assign halted     = r_halted;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed cases plus random traffic
// checked against a queue model of the buffered instructions.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        out_valid, out_ready, halted;
  logic [15:0] in_instr, in_pc, out_pc;
  logic [3:0]  out_opcode, out_rd, out_rs, out_imm;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  bit          halt_m = 1'b0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs     (out_rs),
    .out_imm    (out_imm),
    .out_pc     (out_pc),
    .halted     (halted)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected act_pc=%h act_op=%h req=none",
                 out_pc, out_opcode);
      end else begin
        logic [31:0] e;
        int unsigned w;
        e = q.pop_front();
        w = int'(e[15:0]);
        chk("sb_opcode", 32'(out_opcode), w / 4096);
        chk("sb_rd",     32'(out_rd),     (w / 256) % 16);
        chk("sb_rs",     32'(out_rs),     (w / 16) % 16);
        chk("sb_imm",    32'(out_imm),    w % 16);
        chk("sb_pc",     32'(out_pc),     32'(e[31:16]));
      end
    end
  end

  // One clock of stimulus; expected words are queued on acceptance.
  task automatic step(bit v, logic [15:0] ins, logic [15:0] pc,
                      bit ordy, bit fl, bit r);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    if (!r && !fl && v && in_ready === 1'b1) begin
      q.push_back({pc, ins});
      if (ins[15:12] == 4'hF) halt_m = 1'b1;
    end
    @(posedge clk);
    if (r || fl) begin
      q.delete();
      halt_m = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < 2 && !halt_m));
    chk("halted",    32'(halted),    32'(halt_m));
    if (r) begin
      chk("rst_fields",
          {out_opcode, out_rd, out_rs, out_imm, out_pc}, 32'h0);
    end
  endtask

  initial begin
    logic [15:0] ri;
    bit          rv, ro, rf, rr;

    step(0, 16'h0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0, 1);

    // Streaming at full rate
    step(1, 16'h1234, 16'h0000, 1, 0, 0);
    chk("t1_first_op", 32'(out_opcode), 32'h1);
    step(1, 16'h2345, 16'h0001, 1, 0, 0);
    chk("t1_second_op", 32'(out_opcode), 32'h2);
    step(0, 16'h0, 16'h0, 1, 0, 0);

    // Fill under back-pressure, then drain
    step(1, 16'hA001, 16'h0002, 0, 0, 0);
    step(1, 16'hB002, 16'h0003, 0, 0, 0);
    step(1, 16'h7777, 16'h00FF, 0, 0, 0);
    chk("t2_hold_op", 32'(out_opcode), 32'hA);
    chk("t2_hold_imm", 32'(out_imm), 32'h1);
    step(0, 16'h0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);

    // Flush with two buffered; C003 must never appear
    step(1, 16'h1111, 16'h0004, 0, 0, 0);
    step(1, 16'h2222, 16'h0005, 0, 0, 0);
    step(1, 16'hC003, 16'h0006, 0, 1, 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);

    // HALT shuts fetch, drains, flush releases
    step(1, 16'hF000, 16'h0007, 1, 0, 0);
    step(1, 16'h3333, 16'h0008, 1, 0, 0);
    step(1, 16'h4444, 16'h0009, 1, 0, 0);
    step(1, 16'h5555, 16'h000A, 1, 1, 0);
    step(1, 16'h6543, 16'h000B, 1, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);

    // Reset while full
    step(1, 16'h9ABC, 16'h000C, 0, 0, 0);
    step(1, 16'hDEF1, 16'h000D, 0, 0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 16'h0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ri = 16'($urandom);
      if (ri[15:12] == 4'hF && ($urandom % 4) != 0) ri[15:12] = 4'h5;
      rv = ($urandom % 4) != 0;
      ro = ($urandom % 3) != 0;
      rf = (($urandom % 30) == 0) || (halt_m && ($urandom % 4) == 0);
      rr = ($urandom % 150) == 0;
      step(rv, ri, 16'(i + 16'h100), ro, rf, rr);
    end

    for (int i = 0; i < 8; i++) begin
      if (q.size() != 0) step(0, 16'h0, 16'h0, 1, 0, 0);
    end
    chk("drain_empty", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
